// File: rtl/door_lock_pkg.sv
// Shared types and constants for the door lockout sequencer slice.
package door_lock_pkg;

  localparam int STATE_W      = 2;
  localparam int FAIL_CNT_W   = 3;
  localparam int FAIL_CNT_MAX = 7;
  localparam int AUDIT_W      = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2,
    ALARM    = 2'd3
  } lock_state_e;

endpackage

// File: rtl/lock_countdown_timer.sv
// Seconds countdown shared by the door-open window and the lockout penalty.
module lock_countdown_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             gen_rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  input  logic             i_tick,
  output logic [CNT_W-1:0] o_remaining,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_remaining;

  // A load beats a coincident tick so a fresh window always starts at its full length.
  always_ff @(posedge clk or posedge gen_rst) begin
    if (gen_rst) begin
      r_remaining <= '0;
    end else if (i_clear) begin
      r_remaining <= '0;
    end else if (i_load) begin
      r_remaining <= i_value;
    end else if (i_tick && (r_remaining != '0)) begin
      r_remaining <= r_remaining - 1'b1;
    end
  end

  // Kept independent of i_load/i_clear so the sequencer can arbitrate without a comb loop.
  assign o_expire    = i_tick && (r_remaining == CNT_W'(1));
  assign o_remaining = r_remaining;

endmodule

// File: rtl/door_lockout_sequencer.sv
// Door-lock response sequencer: unlock window, escalating lockout, latched alarm.
// Optional audit counter of ignored password pulses enabled by defining LOCK_AUDIT_EN.
module door_lockout_sequencer
  import door_lock_pkg::*;
#(
  parameter int MAX_FAILS   = 5,
  parameter int BASE_LOCK_S = 10,
  parameter int MAX_LOCK_S  = 60,
  parameter int UNLOCK_S    = 5,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  gen_rst,
  input  logic                  i_sec_tick,
  input  logic                  i_pwd_ok,
  input  logic                  i_pwd_fail,
  input  logic                  i_admin_clear,
  output logic                  o_unlock,
  output logic                  o_lockout,
  output logic                  o_alarm,
  output logic [FAIL_CNT_W-1:0] o_fail_cnt,
  output logic [CNT_W-1:0]      o_remaining_s,
  output logic [AUDIT_W-1:0]    o_ignored_cnt
);

  localparam logic [STATE_W-1:0] ST_IDLE     = IDLE;
  localparam logic [STATE_W-1:0] ST_UNLOCKED = UNLOCKED;
  localparam logic [STATE_W-1:0] ST_LOCKOUT  = LOCKOUT;
  localparam logic [STATE_W-1:0] ST_ALARM    = ALARM;

  localparam int SHIFT_W = CNT_W + 7;

  logic [STATE_W-1:0]    r_state;
  logic [FAIL_CNT_W-1:0] r_failCnt;
  logic                  r_unlock;
  logic                  r_lockout;
  logic                  r_alarm;

  logic [STATE_W-1:0]    w_nextState;
  logic [FAIL_CNT_W-1:0] w_nextFail;
  logic [FAIL_CNT_W-1:0] w_failInc;
  logic [FAIL_CNT_W-1:0] w_shiftIdx;
  logic [SHIFT_W-1:0]    w_shifted;
  logic [CNT_W-1:0]      w_lockDur;
  logic                  w_load;
  logic [CNT_W-1:0]      w_loadValue;
  logic                  w_clear;
  logic [CNT_W-1:0]      w_remaining;
  logic                  w_expire;

  assign w_failInc  = (r_failCnt == FAIL_CNT_W'(FAIL_CNT_MAX)) ? r_failCnt : r_failCnt + 1'b1;
  assign w_shiftIdx = w_failInc - 1'b1;

  // Doubling is done wide enough that seven failures cannot wrap before the clamp.
  assign w_shifted = SHIFT_W'(BASE_LOCK_S) << w_shiftIdx;
  assign w_lockDur = (w_shifted > SHIFT_W'(MAX_LOCK_S)) ? CNT_W'(MAX_LOCK_S)
                                                        : w_shifted[CNT_W-1:0];

  always_comb begin
    w_nextState = r_state;
    w_nextFail  = r_failCnt;
    w_load      = 1'b0;
    w_loadValue = '0;
    w_clear     = 1'b0;
    if (i_admin_clear) begin
      w_nextState = ST_IDLE;
      w_nextFail  = '0;
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_pwd_fail) begin
            w_nextFail = w_failInc;
            if (int'(w_failInc) >= MAX_FAILS) begin
              w_nextState = ST_ALARM;
              w_clear     = 1'b1;
            end else begin
              w_nextState = ST_LOCKOUT;
              w_load      = 1'b1;
              w_loadValue = w_lockDur;
            end
          end else if (i_pwd_ok) begin
            w_nextState = ST_UNLOCKED;
            w_nextFail  = '0;
            w_load      = 1'b1;
            w_loadValue = CNT_W'(UNLOCK_S);
          end
        end
        ST_UNLOCKED: begin
          if (i_pwd_ok) begin
            w_load      = 1'b1;
            w_loadValue = CNT_W'(UNLOCK_S);
          end else if (w_expire) begin
            w_nextState = ST_IDLE;
          end
        end
        ST_LOCKOUT: begin
          if (w_expire) begin
            w_nextState = ST_IDLE;
          end
        end
        default: begin
          w_nextState = r_state;
        end
      endcase
    end
  end

  lock_countdown_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk         (clk),
    .gen_rst     (gen_rst),
    .i_clear     (w_clear),
    .i_load      (w_load),
    .i_value     (w_loadValue),
    .i_tick      (i_sec_tick),
    .o_remaining (w_remaining),
    .o_expire    (w_expire)
  );

  // Status flags are decoded from the next state so they line up with the timer register.
  always_ff @(posedge clk or posedge gen_rst) begin
    if (gen_rst) begin
      r_state   <= ST_IDLE;
      r_failCnt <= '0;
      r_unlock  <= 1'b0;
      r_lockout <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_failCnt <= w_nextFail;
      r_unlock  <= (w_nextState == ST_UNLOCKED);
      r_lockout <= (w_nextState == ST_LOCKOUT) || (w_nextState == ST_ALARM);
      r_alarm   <= (w_nextState == ST_ALARM);
    end
  end

`ifdef LOCK_AUDIT_EN
  logic [AUDIT_W-1:0] r_ignoredCnt;
  logic               w_ignoredPulse;

  assign w_ignoredPulse = (i_pwd_ok || i_pwd_fail) &&
                          ((r_state == ST_LOCKOUT) || (r_state == ST_ALARM));

  always_ff @(posedge clk or posedge gen_rst) begin
    if (gen_rst) begin
      r_ignoredCnt <= '0;
    end else if (i_admin_clear) begin
      r_ignoredCnt <= '0;
    end else if (w_ignoredPulse && (r_ignoredCnt != '1)) begin
      r_ignoredCnt <= r_ignoredCnt + 1'b1;
    end
  end

  assign o_ignored_cnt = r_ignoredCnt;
`else
  assign o_ignored_cnt = '0;
`endif

  assign o_unlock      = r_unlock;
  assign o_lockout     = r_lockout;
  assign o_alarm       = r_alarm;
  assign o_fail_cnt    = r_failCnt;
  assign o_remaining_s = w_remaining;

endmodule

// File: tb/tb_door_lockout_sequencer.sv
// Scoreboard bench for door_lockout_sequencer: directed scenarios then randomized pulses.
module tb_door_lockout_sequencer;

  localparam int MAX_FAILS   = 5;
  localparam int BASE_LOCK_S = 10;
  localparam int MAX_LOCK_S  = 60;
  localparam int UNLOCK_S    = 5;
  localparam int CNT_W       = 8;

  typedef struct packed {
    logic       unlock;
    logic       lockout;
    logic       alarm;
    logic [2:0] failCnt;
    logic [7:0] remaining;
    logic [7:0] ignored;
  } obs_t;

  logic       clk;
  logic       gen_rst;
  logic       secTick;
  logic       pwdOk;
  logic       pwdFail;
  logic       adminClear;
  logic       unlock;
  logic       lockout;
  logic       alarm;
  logic [2:0] failCnt;
  logic [7:0] remainingS;
  logic [7:0] ignoredCnt;

  int   nChecks = 0;
  int   nFails  = 0;
  obs_t expQ[$];

  int mFails;
  int mDoorSecs;
  int mLockSecs;
  bit mAlarm;
  int mIgnored;

  door_lockout_sequencer #(
    .MAX_FAILS   (MAX_FAILS),
    .BASE_LOCK_S (BASE_LOCK_S),
    .MAX_LOCK_S  (MAX_LOCK_S),
    .UNLOCK_S    (UNLOCK_S),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .gen_rst       (gen_rst),
    .i_sec_tick    (secTick),
    .i_pwd_ok      (pwdOk),
    .i_pwd_fail    (pwdFail),
    .i_admin_clear (adminClear),
    .o_unlock      (unlock),
    .o_lockout     (lockout),
    .o_alarm       (alarm),
    .o_fail_cnt    (failCnt),
    .o_remaining_s (remainingS),
    .o_ignored_cnt (ignoredCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t dutObs();
    return '{unlock, lockout, alarm, failCnt, remainingS, ignoredCnt};
  endfunction

  function automatic int lockDur(int n);
    int d = BASE_LOCK_S;
    for (int i = 1; i < n; i++) d = d * 2;
    return (d > MAX_LOCK_S) ? MAX_LOCK_S : d;
  endfunction

  function automatic obs_t modelObs();
    obs_t o;
    o.unlock    = (mDoorSecs > 0);
    o.lockout   = (mLockSecs > 0) || mAlarm;
    o.alarm     = mAlarm;
    o.failCnt   = 3'(mFails);
    o.remaining = mAlarm ? 8'd0 : 8'(mDoorSecs + mLockSecs);
`ifdef LOCK_AUDIT_EN
    o.ignored   = 8'(mIgnored);
`else
    o.ignored   = 8'd0;
`endif
    return o;
  endfunction

  task automatic modelReset();
    mFails = 0; mDoorSecs = 0; mLockSecs = 0; mAlarm = 0; mIgnored = 0;
  endtask

  task automatic bumpIgnored();
    if (mIgnored < 255) mIgnored++;
  endtask

  // Behavioural rules: the door window and the penalty are just seconds left to run.
  task automatic modelStep(input bit ok, input bit fail, input bit tick, input bit clr);
    if (clr) begin
      modelReset();
    end else if (mAlarm) begin
      if (ok || fail) bumpIgnored();
    end else if (mLockSecs > 0) begin
      if (ok || fail) bumpIgnored();
      if (tick) mLockSecs--;
    end else if (mDoorSecs > 0) begin
      if (ok) mDoorSecs = UNLOCK_S;
      else if (tick) mDoorSecs--;
    end else if (fail) begin
      mFails = (mFails < 7) ? mFails + 1 : 7;
      if (mFails >= MAX_FAILS) mAlarm = 1;
      else mLockSecs = lockDur(mFails);
    end else if (ok) begin
      mFails = 0;
      mDoorSecs = UNLOCK_S;
    end
  endtask

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: actual unlock=%0b lockout=%0b alarm=%0b fail=%0d rem=%0d ign=%0d, required unlock=%0b lockout=%0b alarm=%0b fail=%0d rem=%0d ign=%0d",
               name, act.unlock, act.lockout, act.alarm, act.failCnt, act.remaining, act.ignored,
               exp.unlock, exp.lockout, exp.alarm, exp.failCnt, exp.remaining, exp.ignored);
    end
  endtask

  task automatic applyStimulus(input bit ok, input bit fail, input bit tick, input bit clr);
    @(negedge clk);
    pwdOk = ok; pwdFail = fail; secTick = tick; adminClear = clr;
    modelStep(ok, fail, tick, clr);
    expQ.push_back(modelObs());
  endtask

  task automatic tickUntilIdle();
    for (int i = 0; i < 200 && (mLockSecs > 0 || mDoorSecs > 0); i++) applyStimulus(0, 0, 1, 0);
  endtask

  // Monitor: every clock edge presents a new registered response to score.
  always @(posedge clk) begin
    #2;
    if (expQ.size() > 0) checkOutput("cycle", dutObs(), expQ.pop_front());
  end

  initial begin
    gen_rst = 1'b1;
    pwdOk = 0; pwdFail = 0; secTick = 0; adminClear = 0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_state", dutObs(), obs_t'(0));
    gen_rst = 1'b0;

    $display("[TB] single failure lockout");
    applyStimulus(0, 1, 0, 0);
    repeat (10) applyStimulus(0, 0, 1, 0);

    $display("[TB] escalating lockouts into alarm");
    applyStimulus(0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 0, 0);
      tickUntilIdle();
    end
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 0, 1);

    $display("[TB] success after three failures");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, 0);
      tickUntilIdle();
    end
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(1, 0, 1, 0);
    tickUntilIdle();

    $display("[TB] ok and fail together, pulses during lockout");
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);

    $display("[TB] asynchronous reset mid-lockout");
    @(negedge clk);
    pwdOk = 0; pwdFail = 0; secTick = 0; adminClear = 0;
    #2 gen_rst = 1'b1;
    #1 checkOutput("async_reset", dutObs(), obs_t'(0));
    modelReset();
    @(negedge clk);
    gen_rst = 1'b0;

    $display("[TB] randomized pulses");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 20,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
    end

    @(negedge clk);
    pwdOk = 0; pwdFail = 0; secTick = 0; adminClear = 0;
    repeat (2) @(negedge clk);
    nChecks++;
    if (expQ.size() != 0) begin
      nFails++;
      $display("[TB] FAIL drain: actual %0d pending, required 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
